// File: rtl/quiz2_pkg.sv
// Shared counter definitions: mode encoding and width helper.
// Pure declarations; no logic, no latency, no flow control.
package quiz2_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } counter_mode_t;

    // Bits needed to hold 0..max_val-1, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 2) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count for a modulo-MAX_VAL up/down step, wrap or saturate.
// Latency: 0 (pure comb); no backpressure, caller decides when to apply the step.
module counter_next
    import quiz2_pkg::*;
#(
    parameter  int MAX_VAL = 16,
    localparam int WIDTH   = cnt_width(MAX_VAL)
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    input  counter_mode_t    mode_i,
    output logic [WIDTH-1:0] count_nxt_o,
    output logic             bnd_hit_o
);

    // One extra bit so MAX_VAL == 2**WIDTH cannot alias the top value.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MAX_VAL - 1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] nxt_ext;
    logic           unused_msb;

    always_comb begin
        cnt_ext   = {1'b0, count_i};
        nxt_ext   = cnt_ext;
        bnd_hit_o = 1'b0;
        if (up_i) begin
            if (cnt_ext >= TOP) begin
                bnd_hit_o = 1'b1;
                nxt_ext   = (mode_i == CNT_SAT) ? TOP : '0;
            end else begin
                nxt_ext = cnt_ext + 1'b1;
            end
        end else begin
            if (cnt_ext == '0) begin
                bnd_hit_o = 1'b1;
                nxt_ext   = (mode_i == CNT_SAT) ? '0 : TOP;
            end else begin
                nxt_ext = cnt_ext - 1'b1;
            end
        end
    end

    assign count_nxt_o = nxt_ext[WIDTH-1:0];
    assign unused_msb  = nxt_ext[WIDTH];

endmodule

// File: rtl/counter_updn.sv
// Up/down modulo-MAX_VAL counter with clear, clamped load, terminal-count pulse and sticky overflow.
// Latency: 1 cycle, all outputs registered; no backpressure, en gates each step.
module counter_updn
    import quiz2_pkg::*;
#(
    parameter  int MAX_VAL = 16,
    parameter  int MODE    = 0,
    localparam int WIDTH   = cnt_width(MAX_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    generate
        if (MAX_VAL < 2 || MODE < MODE_WRAP || MODE > MODE_SAT) begin : g_bad_param
            $error("counter_updn: MAX_VAL must be >= 2 and MODE must be 0 or 1");
        end
    endgenerate

    localparam counter_mode_t   MODE_SEL = (MODE == MODE_SAT) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH:0]  TOP_EXT  = (WIDTH+1)'(MAX_VAL - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_val;
    logic             step_hit;
    logic [WIDTH-1:0] load_clamped;

    counter_next #(
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count_i     (count_q),
        .up_i        (up),
        .mode_i      (MODE_SEL),
        .count_nxt_o (step_val),
        .bnd_hit_o   (step_hit)
    );

    // Only reachable for non-power-of-two MAX_VAL, but kept unconditional.
    assign load_clamped = ({1'b0, load_val} > TOP_EXT) ? TOP_EXT[WIDTH-1:0] : load_val;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            count_d = step_val;
            if (step_hit) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updn.sv
// Bench for counter_updn: three instances (10/wrap, 10/saturate, 16/wrap) share one stimulus stream,
// each checked every cycle against an arithmetic model plus hand-computed literals.
module tb_counter_updn;

    logic       clk = 1'b0;
    logic       rst, en, up, clr, load;
    logic [3:0] load_val;

    logic [2:0][3:0] d_cnt;
    logic [2:0]      d_tc;
    logic [2:0]      d_ovf;

    int n_chk  = 0;
    int n_err  = 0;
    bit cmp_on = 1'b0;

    int mv[3] = '{10, 10, 16};
    int md[3] = '{0, 1, 0};
    int m_cnt[3];
    int m_tc[3];
    int m_ovf[3];

    always #5 clk = ~clk;

    counter_updn #(.MAX_VAL(10), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(d_cnt[0]), .tc(d_tc[0]), .ovf(d_ovf[0]));
    counter_updn #(.MAX_VAL(10), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(d_cnt[1]), .tc(d_tc[1]), .ovf(d_ovf[1]));
    counter_updn #(.MAX_VAL(16), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(d_cnt[2]), .tc(d_tc[2]), .ovf(d_ovf[2]));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: counter value as a plain integer in 0..M-1.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                m_cnt[k] <= 0; m_tc[k] <= 0; m_ovf[k] <= 0;
            end else if (clr) begin
                m_cnt[k] <= 0; m_tc[k] <= 0; m_ovf[k] <= 0;
            end else if (load) begin
                m_cnt[k] <= (int'(load_val) >= mv[k]) ? mv[k] - 1 : int'(load_val);
                m_tc[k]  <= 0;
            end else if (en && up && m_cnt[k] == mv[k] - 1) begin
                m_cnt[k] <= (md[k] == 1) ? m_cnt[k] : 0;
                m_tc[k]  <= 1; m_ovf[k] <= 1;
            end else if (en && !up && m_cnt[k] == 0) begin
                m_cnt[k] <= (md[k] == 1) ? 0 : mv[k] - 1;
                m_tc[k]  <= 1; m_ovf[k] <= 1;
            end else if (en) begin
                m_cnt[k] <= up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                m_tc[k]  <= 0;
            end else begin
                m_tc[k]  <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_cnt%0d", k), int'(d_cnt[k]), m_cnt[k]);
                chk($sformatf("model_tc%0d", k),  int'(d_tc[k]),  m_tc[k]);
                chk($sformatf("model_ovf%0d", k), int'(d_ovf[k]), m_ovf[k]);
            end
        end
    end

    task automatic drive(input logic c, input logic l, input logic e, input logic u,
                         input logic [3:0] v);
        @(negedge clk);
        clr = c; load = l; en = e; up = u; load_val = v;
        @(posedge clk);
        #1;
    endtask

    // {clr, load, en, up, load_val}
    logic [7:0] vec[8] = '{8'b0011_0000, 8'b0010_0000, 8'b0100_0111, 8'b0011_0000,
                           8'b0011_0000, 8'b0011_0000, 8'b0010_0000, 8'b1011_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset_cnt", int'(d_cnt[k]), 0);
            chk("reset_tc",  int'(d_tc[k]),  0);
            chk("reset_ovf", int'(d_ovf[k]), 0);
        end
        cmp_on = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // Count up 12 edges: wrap at 9, saturate instance pinned at 9.
        for (int i = 1; i <= 12; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            chk("wrap_cnt", int'(d_cnt[0]), i % 10);
            chk("wrap_tc",  int'(d_tc[0]),  (i == 10) ? 1 : 0);
            chk("wrap_ovf", int'(d_ovf[0]), (i >= 10) ? 1 : 0);
        end
        chk("sat_up_cnt", int'(d_cnt[1]), 9);
        chk("pow2_cnt12", int'(d_cnt[2]), 12);

        // Down wrap from 0.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("down_wrap_cnt", int'(d_cnt[0]), 9);
        chk("down_wrap_tc",  int'(d_tc[0]),  1);
        chk("down_sat_cnt",  int'(d_cnt[1]), 0);
        chk("down_pow2_cnt", int'(d_cnt[2]), 15);

        // Saturate up from 8: 9,9,9,9 with tc 0,1,1,1.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            chk("sat_hold_cnt", int'(d_cnt[1]), 9);
            chk("sat_hold_tc",  int'(d_tc[1]),  (i == 0) ? 0 : 1);
            chk("sat_hold_ovf", int'(d_ovf[1]), 1);
        end

        // Saturate down from 1: 0,0,0 with tc 0,1,1.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            chk("sat_floor_cnt", int'(d_cnt[1]), 0);
            chk("sat_floor_tc",  int'(d_tc[1]),  (i == 0) ? 0 : 1);
        end

        // Load clamp beats enable; clear beats everything.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
        chk("clamp_cnt",    int'(d_cnt[0]), 9);
        chk("noclamp_cnt",  int'(d_cnt[2]), 13);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        chk("clr_cnt", int'(d_cnt[0]), 0);
        chk("clr_ovf", int'(d_ovf[0]), 0);
        chk("clr_tc",  int'(d_tc[0]),  0);

        // Power-of-two top value wraps cleanly.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("pow2_wrap_cnt", int'(d_cnt[2]), 0);
        chk("pow2_wrap_tc",  int'(d_tc[2]),  1);

        foreach (vec[i]) drive(vec[i][7], vec[i][6], vec[i][5], vec[i][4], vec[i][3:0]);

        // Async reset between edges at count 5 with ovf set.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("pre_rst_cnt", int'(d_cnt[0]), 5);
        chk("pre_rst_ovf", int'(d_ovf[0]), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_cnt", int'(d_cnt[0]), 0);
        chk("async_rst_tc",  int'(d_tc[0]),  0);
        chk("async_rst_ovf", int'(d_ovf[0]), 0);
        @(negedge clk);
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cnt", int'(d_cnt[0]), 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_updn.md
# counter_updn

Parametrised up/down modulo-N counter, the next-generation general counter for the quiz2 library. Adds direction control, count enable, synchronous clear and parallel load, wrap or saturate mode, a registered terminal-count pulse and a sticky overflow flag. Sits beside the simple free-running counter in `quiz2_lib.v` and is the building block for timers, dividers and FIFO pointers.

## Interface
- `MAX_VAL`, 16: modulus; count range is 0..MAX_VAL-1; legal values are ≥ 2, and non-powers of two are allowed.
- `MODE`, 0: 0 = wrap (modulo), 1 = saturate at the bounds.
- `WIDTH`: derived localparam, not overridable; `$clog2(MAX_VAL)`, minimum 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; one step per enabled cycle.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value for `load`.
- `count`  out  WIDTH  current count (registered).
- `tc`  out  1  registered one-cycle terminal-count pulse.
- `ovf`  out  1  sticky overflow/underflow flag.

## Operation
- Reset (`rst`=0, asynchronous): `count`=0, `tc`=0, `ovf`=0. All three are held while `rst` is low. After `rst` is released, the first rising edge behaves normally.
- Per-edge priority: `clr` > `load` > `en` > hold.
- `clr`: `count`←0, `tc`←0, `ovf`←0.
- `load`: `count`←`load_val`. If `load_val` ≥ MAX_VAL, `count`←MAX_VAL-1 (clamped). `tc`←0, and `ovf` is unchanged.
- `en` and `up`=1:
  - At count < MAX_VAL-1: `count`+1.
  - At MAX_VAL-1, wrap mode: `count`←0, `tc`←1, `ovf`←1.
  - At MAX_VAL-1, saturate mode: `count` holds at MAX_VAL-1, `tc`←1, `ovf`←1.
- `en` and `up`=0:
  - At count > 0: `count`-1.
  - At 0, wrap mode: `count`←MAX_VAL-1, `tc`←1, `ovf`←1.
  - At 0, saturate mode: `count` holds at 0, `tc`←1, `ovf`←1.
- `tc` is 0 on every edge not listed above, so it is a single-cycle pulse per boundary event. In saturate mode, with `en` held at the bound, `tc` stays high for as long as steps are being blocked.
- `ovf` is sticky. Only `clr` or reset clears it.
- Arithmetic is done in WIDTH+1 bits internally, so MAX_VAL = 2^WIDTH cannot alias. `count` never leaves 0..MAX_VAL-1.
- `up` changing mid-run takes effect on the next enabled edge; there is no pipeline.

## Timing
- Latency: `count`, `tc` and `ovf` update on the same rising edge that samples the controls. There are no combinational paths from inputs to outputs.
- `tc` is high for exactly the one cycle after the boundary edge, aligned with the new `count`.
- `rst` asserted mid-count clears the outputs immediately, not at the next edge.
- `clr`, `load` and `en` all high together: the clear wins, giving `count`=0.
- `load` and `en` together: the load wins, with no additional step in that cycle.

## Structure
- Shared package `quiz2_pkg`:
  - `MODE_WRAP`=0 and `MODE_SAT`=1 constants.
  - A `counter_mode_t` typedef for `MODE`.
- Sub-module `counter_next`: purely combinational next-state logic.
  - Inputs: count, up, mode.
  - Outputs: next count, boundary hit.
  - Reusable by FIFO pointer logic.
- The top level holds the registers, the priority mux, the `tc` and `ovf` flops, and the load clamp.
- Parameter check: an elaboration-time error if MAX_VAL < 2 or MODE > 1.

## Test plan
- Reset/wrap: MAX_VAL=10, MODE=0, `rst`=0 then 1, `en`=1, `up`=1 for 12 edges -> `count` 0,1,…,9,0,1; `tc`=1 only in the cycle `count` returns to 0; `ovf`=1 from then on.
- Down wrap: MAX_VAL=10, load 0, `up`=0, one enabled edge -> `count`=9, `tc` pulse, `ovf`=1.
- Saturate: MAX_VAL=10, MODE=1, load 8, `up`=1, `en`=1 for 4 edges -> `count` 9,9,9,9; `tc` 0,1,1,1; `ovf`=1. The same check at 0 counting down gives `count` stuck at 0.
- Load clamp and priority: MAX_VAL=10, `load_val`=13 with `load`=1 and `en`=1 -> `count`=9. Then `clr`, `load` and `en` all high -> `count`=0, `ovf`=0.
- Power-of-two edge: MAX_VAL=16, WIDTH=4, from count 15, `up`=1, `en`=1 -> `count`=0 and `tc`=1, with no aliasing.
- Async reset mid-run: assert `rst`=0 between edges at `count`=5 -> `count`=0, `tc`=0 and `ovf`=0 immediately; the first edge after release with `en`=1 -> `count`=1.
